// File: rtl/operand_fetch.sv
// Decode-stage operand fetch: register file, pending-write scoreboard, bypass, operand/sign select.
// Latency: 1 cycle from accept to out_valid; 1 instruction/cycle with no hazard and out_ready high.
// Backpressure: in_ready drops on hazard, flush, or a held output (out_valid & !out_ready); out_* hold while stalled.
module operand_fetch #(
    parameter int XLEN    = 32,
    parameter int REG_NUM = 16,
    parameter int AW      = $clog2(REG_NUM),
    parameter bit R0_ZERO = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [AW-1:0]   in_rs1,
    input  logic [AW-1:0]   in_rs2,
    input  logic [AW-1:0]   in_rd,
    input  logic            in_rs1_en,
    input  logic            in_rs2_en,
    input  logic            in_imm_en,
    input  logic [XLEN-1:0] in_imm,
    input  logic            in_s1_sign,
    input  logic            in_s2_sign,
    input  logic            in_wb_en,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_s1,
    output logic [XLEN-1:0] out_s2,
    output logic            out_s1_sign,
    output logic            out_s2_sign,
    output logic [AW-1:0]   out_rd,
    output logic            out_wb_en
);

    typedef struct packed {
        logic [XLEN-1:0] s1;
        logic [XLEN-1:0] s2;
        logic            s1_sign;
        logic            s2_sign;
        logic [AW-1:0]   rd;
        logic            wb_en;
    } op_t;

    logic [XLEN-1:0]    rf [REG_NUM];
    logic [REG_NUM-1:0] busy;
    logic [REG_NUM-1:0] busy_nxt;
    logic [XLEN-1:0]    rs1_val;
    logic [XLEN-1:0]    rs2_val;
    logic               hazard;
    logic               accept;
    logic               rf_we;
    op_t                nxt;
    op_t                out_q;

    // Read priority: hardwired zero, then same-cycle write-back, then stored entry.
    function automatic logic [XLEN-1:0] resolve(
        input logic [AW-1:0]   a,
        input logic [XLEN-1:0] rf_val,
        input logic            wv,
        input logic [AW-1:0]   wa,
        input logic [XLEN-1:0] wd
    );
        if (R0_ZERO && (a == '0))
            return '0;
        else if (wv && (wa == a))
            return wd;
        else
            return rf_val;
    endfunction

    // A register whose write-back lands this cycle is no longer a hazard.
    function automatic logic pending(
        input logic [REG_NUM-1:0] bsy,
        input logic [AW-1:0]      r,
        input logic               wv,
        input logic [AW-1:0]      wa
    );
        return bsy[r] && !(wv && (wa == r));
    endfunction

    assign rs1_val = resolve(in_rs1, rf[in_rs1], wb_valid, wb_addr, wb_data);
    assign rs2_val = resolve(in_rs2, rf[in_rs2], wb_valid, wb_addr, wb_data);

    assign hazard = (in_rs1_en && pending(busy, in_rs1, wb_valid, wb_addr))
                  || (in_rs2_en && !in_imm_en && pending(busy, in_rs2, wb_valid, wb_addr))
                  || (in_wb_en && pending(busy, in_rd, wb_valid, wb_addr));

    // in_valid deliberately absent so the upstream can wait on in_ready.
    assign in_ready = !flush && !hazard && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign rf_we    = wb_valid && !(R0_ZERO && (wb_addr == '0));

    // Operand select and sign flags for the instruction being accepted.
    always_comb begin
        nxt       = '0;
        nxt.s1    = in_rs1_en ? rs1_val : '0;
        nxt.s2    = in_imm_en ? in_imm : (in_rs2_en ? rs2_val : '0);
        nxt.s1_sign = in_s1_sign && nxt.s1[XLEN-1];
        nxt.s2_sign = in_s2_sign && nxt.s2[XLEN-1];
        nxt.rd    = in_rd;
        nxt.wb_en = in_wb_en;
    end

    // Scoreboard next state: clear on write-back, then set on accept so set wins.
    always_comb begin
        busy_nxt = busy;
        if (wb_valid)
            busy_nxt[wb_addr] = 1'b0;
        if (accept && in_wb_en && !(R0_ZERO && (in_rd == '0)))
            busy_nxt[in_rd] = 1'b1;
        if (flush)
            busy_nxt = '0;
    end

    // Scoreboard register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            busy <= '0;
        else
            busy <= busy_nxt;
    end

    // Register file; write-back still lands during a flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++)
                rf[i] <= '0;
        end else if (rf_we) begin
            rf[wb_addr] <= wb_data;
        end
    end

    // Execute-stage output register: flush beats accept, accept beats drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q     <= '0;
            out_valid <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_q     <= nxt;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign out_s1      = out_q.s1;
    assign out_s2      = out_q.s2;
    assign out_s1_sign = out_q.s1_sign;
    assign out_s2_sign = out_q.s2_sign;
    assign out_rd      = out_q.rd;
    assign out_wb_en   = out_q.wb_en;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: RF/bypass, immediate priority, scoreboard stalls, backpressure, flush, reset.
// Latency: outputs checked 1 ns after the edge that accepts; in_ready checked 1 ns after inputs change.
// Backpressure: out_ready is driven directly by the bench to hold and release the output register.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_rs1 = '0;
    logic [3:0]  in_rs2 = '0;
    logic [3:0]  in_rd = '0;
    logic        in_rs1_en = 1'b0;
    logic        in_rs2_en = 1'b0;
    logic        in_imm_en = 1'b0;
    logic [31:0] in_imm = '0;
    logic        in_s1_sign = 1'b0;
    logic        in_s2_sign = 1'b0;
    logic        in_wb_en = 1'b0;
    logic        wb_valid = 1'b0;
    logic [3:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_s1;
    logic [31:0] out_s2;
    logic        out_s1_sign;
    logic        out_s2_sign;
    logic [3:0]  out_rd;
    logic        out_wb_en;

    int total = 0;
    int bad = 0;

    operand_fetch dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_rs1_en(in_rs1_en), .in_rs2_en(in_rs2_en), .in_imm_en(in_imm_en),
        .in_imm(in_imm), .in_s1_sign(in_s1_sign), .in_s2_sign(in_s2_sign),
        .in_wb_en(in_wb_en),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_s1(out_s1), .out_s2(out_s2),
        .out_s1_sign(out_s1_sign), .out_s2_sign(out_s2_sign),
        .out_rd(out_rd), .out_wb_en(out_wb_en)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] rs1, input logic e1, input logic [3:0] rs2, input logic e2,
                         input logic [31:0] imm, input logic ie, input logic [3:0] rd, input logic we,
                         input logic sg1, input logic sg2);
        in_valid = 1'b1;
        in_rs1 = rs1; in_rs1_en = e1;
        in_rs2 = rs2; in_rs2_en = e2;
        in_imm = imm; in_imm_en = ie;
        in_rd = rd; in_wb_en = we;
        in_s1_sign = sg1; in_s2_sign = sg2;
    endtask

    task automatic noissue();
        in_valid = 1'b0; in_rs1_en = 1'b0; in_rs2_en = 1'b0; in_imm_en = 1'b0; in_wb_en = 1'b0;
        in_s1_sign = 1'b0; in_s2_sign = 1'b0;
    endtask

    task automatic wb(input logic [3:0] a, input logic [31:0] d);
        wb_valid = 1'b1; wb_addr = a; wb_data = d;
    endtask

    initial begin
        // Reset state
        tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_s1", out_s1, 0);
        chk("rst_out_s2", out_s2, 0);
        chk("rst_out_rd", out_rd, 0);
        rst = 1'b0;

        // Load r1=5, r2=7, r3=0x80000000
        wb(1, 32'd5); tick();
        wb(2, 32'd7); tick();
        wb(3, 32'h8000_0000); tick();
        wb_valid = 1'b0;

        // Back-to-back {rs1=1, rs2=2}; sign requested on a positive value
        issue(1, 1, 2, 1, 0, 0, 0, 0, 1, 1);
        #1 chk("b2b_ready0", in_ready, 1);
        tick();
        chk("b2b_valid0", out_valid, 1);
        chk("b2b_s1_0", out_s1, 5);
        chk("b2b_s2_0", out_s2, 7);
        chk("b2b_sign_pos", {out_s1_sign, out_s2_sign}, 0);
        chk("b2b_ready1", in_ready, 1);
        tick();
        chk("b2b_valid1", out_valid, 1);
        chk("b2b_s1_1", out_s1, 5);
        chk("b2b_s2_1", out_s2, 7);

        // Immediate wins over rs2; both sign flags set
        issue(3, 1, 2, 1, 32'hFFFF_FFF0, 1, 0, 0, 1, 1);
        tick();
        chk("imm_s2", out_s2, 32'hFFFF_FFF0);
        chk("imm_s1", out_s1, 32'h8000_0000);
        chk("imm_s1_sign", out_s1_sign, 1);
        chk("imm_s2_sign", out_s2_sign, 1);
        noissue(); tick();
        chk("drain_valid", out_valid, 0);

        // RAW: A writes r4, B reads r4
        issue(0, 0, 0, 0, 0, 0, 4, 1, 0, 0);
        tick();
        chk("raw_a_rd", out_rd, 4);
        chk("raw_a_wben", out_wb_en, 1);
        issue(4, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("raw_stall0", in_ready, 0);
        tick();
        chk("raw_stall1", in_ready, 0);
        chk("raw_bubble", out_valid, 0);
        wb(4, 32'h1234);
        #1 chk("raw_wb_ready", in_ready, 1);
        tick();
        wb_valid = 1'b0;
        chk("raw_bypass_valid", out_valid, 1);
        chk("raw_bypass_s1", out_s1, 32'h1234);
        #1 chk("raw_busy_clear", in_ready, 1);
        tick();
        chk("raw_rf_s1", out_s1, 32'h1234);
        noissue(); tick();

        // Backpressure: D held for 3 cycles while E waits
        out_ready = 1'b0;
        issue(1, 1, 0, 0, 32'h11, 1, 0, 0, 0, 0);
        #1 chk("bp_d_ready", in_ready, 1);
        tick();
        issue(2, 1, 0, 0, 32'h22, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            chk("bp_hold_ready", in_ready, 0);
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_s1", out_s1, 5);
            chk("bp_hold_s2", out_s2, 32'h11);
            tick();
        end
        out_ready = 1'b1;
        #1 chk("bp_release_ready", in_ready, 1);
        tick();
        noissue();
        chk("bp_e_valid", out_valid, 1);
        chk("bp_e_s1", out_s1, 7);
        chk("bp_e_s2", out_s2, 32'h22);
        tick();
        chk("bp_no_dup", out_valid, 0);

        // r0: write dropped and never bypassed
        wb(0, 32'hDEAD);
        issue(0, 1, 0, 1, 0, 0, 0, 1, 1, 1);
        tick();
        wb_valid = 1'b0;
        chk("r0_bypass", out_s1, 0);
        chk("r0_bypass_s2", out_s2, 0);
        issue(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("r0_never_busy", in_ready, 1);
        tick();
        chk("r0_rf", out_s1, 0);

        // WAW on r5
        issue(0, 0, 0, 0, 0, 0, 5, 1, 0, 0);
        tick();
        chk("waw_w1_valid", out_valid, 1);
        #1 chk("waw_stall0", in_ready, 0);
        tick();
        chk("waw_stall1", in_ready, 0);
        wb(5, 32'h55);
        #1 chk("waw_release", in_ready, 1);
        tick();
        wb_valid = 1'b0;
        chk("waw_w2_rd", out_rd, 5);
        issue(5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("waw_set_wins", in_ready, 0);
        wb(5, 32'h66);
        #1 chk("waw_consumer_ready", in_ready, 1);
        tick();
        wb_valid = 1'b0;
        chk("waw_consumer_s1", out_s1, 32'h66);
        noissue(); tick();

        // Flush with busy[6] and a held output; flush-cycle write-back to r7
        out_ready = 1'b0;
        issue(0, 0, 0, 0, 0, 0, 6, 1, 0, 0);
        tick();
        chk("fl_p_valid", out_valid, 1);
        issue(6, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        flush = 1'b1;
        wb(7, 32'h77);
        #1 chk("fl_no_accept", in_ready, 0);
        tick();
        flush = 1'b0;
        wb_valid = 1'b0;
        chk("fl_valid_cleared", out_valid, 0);
        #1 chk("fl_busy_cleared", in_ready, 1);
        tick();
        chk("fl_consumer_valid", out_valid, 1);
        chk("fl_consumer_s1", out_s1, 0);
        out_ready = 1'b1;
        issue(7, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("fl_wb_kept", out_s1, 32'h77);
        noissue(); tick();

        // Async reset mid-stall
        issue(1, 1, 0, 0, 0, 0, 8, 1, 0, 0);
        tick();
        chk("rs_x_rd", out_rd, 8);
        chk("rs_x_s1", out_s1, 5);
        issue(8, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        #1 chk("rs_stall", in_ready, 0);
        #2 rst = 1'b1;
        #1;
        chk("rs_async_valid", out_valid, 0);
        chk("rs_async_s1", out_s1, 0);
        chk("rs_async_rd", out_rd, 0);
        chk("rs_async_wben", out_wb_en, 0);
        tick();
        rst = 1'b0;
        #1 chk("rs_busy_reset", in_ready, 1);
        tick();
        chk("rs_after_valid", out_valid, 1);
        chk("rs_rf_reset", out_s2, 0);
        noissue(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Parametrised decode-stage source-operand fetch unit. It holds the integer register file and a pending-write scoreboard, and selects operand 2 from a register or an immediate. It bypasses same-cycle write-back data and registers the resolved operands and sign flags into the execute stage behind a valid/ready handshake. It replaces the fixed 16-entry, purely combinational operand path: hazards now stall here instead of being left to software.

## Interface
- XLEN, 32, operand/register width
- REG_NUM, 16, number of architectural registers
- AW, $clog2(REG_NUM), register address width
- R0_ZERO, 1, 1: register 0 reads 0, ignores writes and is never marked busy
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous pipeline flush
- in_valid / in_ready  in / out  1  decode-side handshake
- in_rs1, in_rs2, in_rd  in  AW each  source and destination addresses
- in_rs1_en, in_rs2_en, in_imm_en  in  1 each  operand enables
- in_imm  in  XLEN  immediate, already extended by the decoder
- in_s1_sign, in_s2_sign  in  1 each  signed-operand request
- in_wb_en  in  1  instruction will write in_rd
- wb_valid  in  1  write-back strobe
- wb_addr  in  AW  write-back address
- wb_data  in  XLEN  write-back data
- out_valid / out_ready  out / in  1  execute-side handshake
- out_s1, out_s2  out  XLEN  resolved operands
- out_s1_sign, out_s2_sign  out  1 each  operand is signed and negative
- out_rd  out  AW  destination address
- out_wb_en  out  1  destination write enable

## Operation
- **Register file.** REG_NUM×XLEN flops, written when wb_valid is high; a write to r0 is dropped when R0_ZERO=1.
- **Read value.** The read value of rsX is:
  - 0 if R0_ZERO and rsX = 0;
  - otherwise wb_data if wb_valid and wb_addr = rsX (same-cycle bypass);
  - otherwise the RF entry.
- **Operand select.**
  - s1 = rs1_en ? rs1 value : 0.
  - s2 = imm_en ? in_imm : (rs2_en ? rs2 value : 0). Immediate has priority when both enables are set.
- **Sign flags.**
  - s1_sign = in_s1_sign & s1[XLEN-1].
  - s2_sign = in_s2_sign & s2[XLEN-1].
- **Scoreboard.** busy[REG_NUM].
  - Set on accept when in_wb_en = 1, for in_rd.
  - Cleared by wb_valid, for wb_addr.
  - Same register set and cleared in the same cycle: set wins.
- **Hazard.** Asserted when any of these holds, where cleared(r) = wb_valid and wb_addr = r:
  - (rs1_en & busy[rs1] & !cleared(rs1));
  - (rs2_en & !imm_en & busy[rs2] & !cleared(rs2));
  - (in_wb_en & busy[rd] & !cleared(rd)), i.e. a WAW stall.
- **Handshake.**
  - in_ready = !flush & !hazard & (!out_valid | out_ready).
  - accept = in_valid & in_ready.
  - in_ready never depends on in_valid.
- **Output register.**
  - On accept: load out_* and set out_valid.
  - Else if out_ready: clear out_valid.
  - While out_valid & !out_ready, out_* hold stable.
- **Flush.** Highest priority:
  - Clears out_valid and all busy bits next edge.
  - Accepts nothing that cycle.
  - RF contents are kept, and a wb_valid in the flush cycle still writes the RF.
- **Reset.**
  - out_valid = 0.
  - out_s1, out_s2, out_rd, out_wb_en, and both sign flags = 0.
  - Busy bits = 0 and RF entries = 0.

## Timing
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 instruction per cycle with no hazard and out_ready held high.
- RAW: producer accepted at edge N, so busy is set from N+1. A consumer in cycle N+k stalls until the cycle wb_valid targets its source. It is accepted in that same cycle with bypassed data, giving zero added bubble after write-back.
- Write-back writes the RF at the same edge the consumer is accepted, so there is no read-before-write window.
- in_ready is combinational from out_ready, wb_valid/wb_addr and flush. There is no combinational path from in_* data to out_*.
- Reset is asserted asynchronously and released synchronously by the environment. A mid-transfer reset drops the in-flight instruction.

## Test plan
- **Reset then back-to-back ops.** Set r1=5, r2=7 via wb, then issue {rs1=1, rs2=2} twice with out_ready=1. Required: out_s1=5 and out_s2=7 on two consecutive cycles, and in_ready held at 1.
- **Immediate priority and sign.** Issue rs1=3 (r3=0x8000_0000), rs2_en=1, imm_en=1, imm=0xFFFF_FFF0, both sign requests set. Required: out_s2=0xFFFF_FFF0, out_s1_sign=1, out_s2_sign=1.
- **RAW stall and bypass.**
  - Issue A {rd=4, wb_en}, then B {rs1=4}.
  - B must see in_ready=0 until wb_valid with wb_addr=4 and wb_data=0x1234.
  - B is accepted in that cycle and shows out_s1=0x1234; busy[4] clears.
- **Backpressure.** Hold out_ready=0 for 3 cycles with in_valid=1. Required: out_* stable, in_ready=0, and no instruction lost or duplicated after release.
- **R0 and WAW.**
  - wb to r0 with 0xDEAD: rs1=0 still reads 0.
  - Two writers to r5: the second stalls until the first's write-back.
  - Simultaneous accept to r5 with a wb to r5: busy[5] stays 1.
- **Flush and async reset.**
  - flush with busy[6]=1 and out_valid=1: next cycle out_valid=0, busy cleared, and a consumer of r6 is accepted.
  - rst pulse mid-stall: all outputs 0 immediately.
